timer_apb_arbiter: RTL
======================

# timer_apb_arbiter

Two-requester APB master that shares the timer register block (status, goal, current) between two independent clients. Each client presents a single-register read or write command. The arbiter grants round-robin, runs the APB SETUP/ACCESS sequence toward the timer, and returns read data and error status to the granted client. It sits between the control logic and the timer's APB slave port; it is the only master on that bus.

## Interface
Parameters:
- addrWidth, 2, APB address width (timer register index)
- timerbits, 8, APB data width
- timeoutCycles, 15, ACCESS-phase cycle limit; only used with TIMER_ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- req_valid  in  2  bit i = client i has a pending command; held until req_ready[i]
- req_write  in  2  bit i = 1 write, 0 read
- req_addr  in  2*addrWidth  client i address in slice [i*addrWidth +: addrWidth]
- req_wdata  in  2*timerbits  client i write data in slice [i*timerbits +: timerbits]
- req_ready  out  2  one-cycle pulse; command i captured
- rsp_valid  out  2  one-cycle pulse; response for client i valid
- rsp_rdata  out  timerbits  read data, shared; valid with rsp_valid
- rsp_err  out  1  slave error or timeout, shared; valid with rsp_valid
- sel, enable, write  out  1  APB master controls
- addr  out  addrWidth  APB address
- wdata  out  timerbits  APB write data
- rdata  in  timerbits  APB read data
- ready  in  1  APB transfer complete
- slverr  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - With no req_valid, stay in IDLE.
  - Otherwise grant g. If one bit is set, grant that client. If both are set, grant the client other than last_grant.
  - last_grant resets to 1, so client 0 wins the first tie.
  - On grant, latch write/addr/wdata of g, pulse req_ready[g], and go to SETUP.
- SETUP: sel=1, enable=0, addr/write/wdata driven from the latch. Next state is ACCESS unconditionally.
- ACCESS: sel=1, enable=1. Stay until ready=1.
  - On ready, capture rsp_err=slverr.
  - Capture rsp_rdata=rdata for a read, or 0 for a write.
  - Go to RESP.
- RESP: sel=0, enable=0, rsp_valid[g]=1 for exactly one cycle, last_grant=g. Next state is IDLE.
- Address, write and wdata stay stable from SETUP through the end of ACCESS. In IDLE and RESP they hold their last values.
- If a client drops req_valid before req_ready, the command is withdrawn with no bus activity.
- Commands to unmapped addresses (index 3) are issued unchanged. Error reporting is the slave's job.
- A write to the current-value register returns rsp_err=1 via slverr. The arbiter does no special handling.
- The arbiter has no queueing. Only one transaction is outstanding at a time.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, sel=0, enable=0, write=0, addr=0, wdata=0.
- All outputs are registered.
- Grant cycle T0 is the req_ready pulse. SETUP is T1. ACCESS starts at T2.
  - With ready at T2, RESP occurs at T3 (rsp_valid high).
  - The earliest next grant is T4.
  - The minimum cost is 4 cycles per transaction.
- Each extra ACCESS wait cycle adds 1 cycle.
- req_valid from a client during its own RESP cycle is not granted before IDLE.
- Reset asserted mid-transaction:
  - sel and enable drop asynchronously.
  - No rsp_valid is issued for the aborted command.
  - The client must re-request.

## Configuration
- TIMER_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with ready=0.
  - When it reaches timeoutCycles, the FSM leaves ACCESS next cycle with sel=0 and enable=0.
  - Then RESP with rsp_err=1 and rsp_rdata=0.
- TIMER_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits for ready indefinitely.

## Test plan
- Single read: client 0 reads addr 1, slave returns 0x3C with ready at the first ACCESS cycle.
  - Expect req_ready[0] at T0, sel=1/enable=0 at T1, enable=1 at T2.
  - Expect rsp_valid[0]=1, rsp_rdata=0x3C, rsp_err=0 at T3.
- Simultaneous requests: both clients request from reset, client 0 writes 0x05 to addr 0 and client 1 reads addr 2.
  - Expect client 0 granted first and client 1 granted at the next IDLE.
  - Expect exactly two transactions and rsp_valid pulses in order 0 then 1.
- Fairness: both clients hold req_valid for 6 transactions. Grants alternate 0,1,0,1,0,1.
- Wait states and error: the slave holds ready low for 3 ACCESS cycles and then returns slverr=1 on a write to addr 2.
  - Expect RESP 3 cycles later than minimum, rsp_err=1, rsp_rdata=0.
- Reset mid-operation: assert reset during ACCESS.
  - Expect sel=0 and enable=0 immediately, and no rsp_valid.
  - After release, a new client 1 request completes normally with client 1 winning a tie only if last_grant=0.
- Timeout (macro on, timeoutCycles=4): the slave never asserts ready.
  - Expect rsp_valid with rsp_err=1 after 4 ACCESS cycles, then bus idle.

Source files
------------

// File: rtl/timer_apb_arbiter.sv
// Two-client round-robin APB master for the timer register block (status, goal, current).
// Optional ACCESS-phase timeout is enabled with `define TIMER_ARB_TIMEOUT_EN.
module timer_apb_arbiter #(
  parameter int unsigned addrWidth     = 2,
  parameter int unsigned timerbits     = 8,
  parameter int unsigned timeoutCycles = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_write,
  input  logic [2*addrWidth-1:0] req_addr,
  input  logic [2*timerbits-1:0] req_wdata,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic [timerbits-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic                   sel,
  output logic                   enable,
  output logic                   write,
  output logic [addrWidth-1:0]   addr,
  output logic [timerbits-1:0]   wdata,
  input  logic [timerbits-1:0]   rdata,
  input  logic                   ready,
  input  logic                   slverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                 state_r;
  logic                   grant_r;
  logic                   last_grant_r;
  logic [1:0]             req_ready_r;
  logic [1:0]             rsp_valid_r;
  logic [timerbits-1:0]   rsp_rdata_r;
  logic                   rsp_err_r;
  logic                   sel_r;
  logic                   enable_r;
  logic                   write_r;
  logic [addrWidth-1:0]   addr_r;
  logic [timerbits-1:0]   wdata_r;

  logic                   eff_last_s;
  logic                   can_grant_s;
  logic                   grant_s;
  logic                   do_grant_s;
  logic                   sel_write_s;
  logic [addrWidth-1:0]   sel_addr_s;
  logic [timerbits-1:0]   sel_wdata_s;

`ifdef TIMER_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(timeoutCycles + 1);
  logic [CNT_W-1:0] cnt_r;
`endif

  function automatic logic [1:0] grant_onehot(input logic g);
    logic [1:0] oh;
    if (g) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

  // Round-robin arbitration; a RESP cycle already counts its own client as the last grant
  always_comb begin
    eff_last_s  = last_grant_r;
    can_grant_s = 1'b0;
    grant_s     = 1'b0;
    if (state_r == RESP) begin
      eff_last_s = grant_r;
    end else begin
      eff_last_s = last_grant_r;
    end
    if (((state_r == IDLE) && (req_ready_r == 2'b00)) || (state_r == RESP)) begin
      can_grant_s = 1'b1;
    end else begin
      can_grant_s = 1'b0;
    end
    if (req_valid == 2'b11) begin
      grant_s = ~eff_last_s;
    end else if (req_valid[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    do_grant_s = can_grant_s && (req_valid != 2'b00);
    if (grant_s) begin
      sel_write_s = req_write[1];
      sel_addr_s  = req_addr[addrWidth +: addrWidth];
      sel_wdata_s = req_wdata[timerbits +: timerbits];
    end else begin
      sel_write_s = req_write[0];
      sel_addr_s  = req_addr[0 +: addrWidth];
      sel_wdata_s = req_wdata[0 +: timerbits];
    end
  end

  // Grant pulse and command latch; addr/write/wdata double as the APB outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready_r <= 2'b00;
      grant_r     <= 1'b0;
      write_r     <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
    end else if (do_grant_s) begin
      req_ready_r <= grant_onehot(grant_s);
      grant_r     <= grant_s;
      write_r     <= sel_write_s;
      addr_r      <= sel_addr_s;
      wdata_r     <= sel_wdata_s;
    end else begin
      req_ready_r <= 2'b00;
    end
  end

  // Bus sequencing FSM with registered APB controls and client responses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      rsp_valid_r  <= 2'b00;
      rsp_rdata_r  <= '0;
      rsp_err_r    <= 1'b0;
      sel_r        <= 1'b0;
      enable_r     <= 1'b0;
`ifdef TIMER_ARB_TIMEOUT_EN
      cnt_r        <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 2'b00;
          if (req_ready_r != 2'b00) begin
            sel_r    <= 1'b1;
            enable_r <= 1'b0;
            state_r  <= SETUP;
          end else begin
            state_r  <= IDLE;
          end
        end
        SETUP: begin
          enable_r <= 1'b1;
          state_r  <= ACCESS;
`ifdef TIMER_ARB_TIMEOUT_EN
          cnt_r    <= '0;
`endif
        end
        ACCESS: begin
          if (ready) begin
            sel_r       <= 1'b0;
            enable_r    <= 1'b0;
            rsp_valid_r <= grant_onehot(grant_r);
            rsp_err_r   <= slverr;
            rsp_rdata_r <= write_r ? '0 : rdata;
            state_r     <= RESP;
`ifdef TIMER_ARB_TIMEOUT_EN
          end else if (cnt_r == CNT_W'(timeoutCycles - 1)) begin
            // Last permitted wait cycle: abandon the transfer and report an error
            sel_r       <= 1'b0;
            enable_r    <= 1'b0;
            rsp_valid_r <= grant_onehot(grant_r);
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= '0;
            state_r     <= RESP;
          end else begin
            cnt_r       <= cnt_r + CNT_W'(1);
          end
`else
          end else begin
            state_r     <= ACCESS;
          end
`endif
        end
        RESP: begin
          rsp_valid_r  <= 2'b00;
          last_grant_r <= grant_r;
          state_r      <= IDLE;
        end
        default: begin
          sel_r       <= 1'b0;
          enable_r    <= 1'b0;
          rsp_valid_r <= 2'b00;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign sel       = sel_r;
  assign enable    = enable_r;
  assign write     = write_r;
  assign addr      = addr_r;
  assign wdata     = wdata_r;

endmodule
